// File: rtl/des_key_schedule.sv
// DES key schedule: accepts a 64-bit key and streams the 16 round subkeys
// (forward for encryption, reversed for decryption) over a valid/ready port.
module des_key_schedule (
   input  logic        clk,
   input  logic        rst,
   input  logic [0:63] key_in,
   input  logic        key_decrypt,
   input  logic        key_valid,
   output logic        key_ready,
   output logic [0:47] subkey,
   output logic [3:0]  subkey_round,
   output logic        subkey_last,
   output logic        subkey_valid,
   input  logic        subkey_ready
);

   // PC-1 / PC-2 stored 0-based (DES bit n -> index n-1), MSB-first.
   localparam logic [5:0] PC1 [56] = '{
      6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,
      6'd0,  6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17,
      6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26,
      6'd18, 6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35,
      6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14,
      6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21,
      6'd13, 6'd5,  6'd60, 6'd52, 6'd44, 6'd36, 6'd28,
      6'd20, 6'd12, 6'd4,  6'd27, 6'd19, 6'd11, 6'd3};

   localparam logic [5:0] PC2 [48] = '{
      6'd13, 6'd16, 6'd10, 6'd23, 6'd0,  6'd4,
      6'd2,  6'd27, 6'd14, 6'd5,  6'd20, 6'd9,
      6'd22, 6'd18, 6'd11, 6'd3,  6'd25, 6'd7,
      6'd15, 6'd6,  6'd26, 6'd19, 6'd12, 6'd1,
      6'd40, 6'd51, 6'd30, 6'd36, 6'd46, 6'd54,
      6'd29, 6'd39, 6'd50, 6'd44, 6'd32, 6'd47,
      6'd43, 6'd48, 6'd38, 6'd55, 6'd33, 6'd52,
      6'd45, 6'd41, 6'd49, 6'd35, 6'd28, 6'd31};

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [0:27] c_q, d_q;
   logic [3:0]  cnt_q;
   logic        mode_q;      // 1 = decrypt (reverse order)
   logic        accept, advance;
   logic [0:55] cd0;

   function automatic logic [0:55] pc1(input logic [0:63] k);
      logic [0:55] r;
      for (int i = 0; i < 56; i++) r[i] = k[PC1[i]];
      return r;
   endfunction

   function automatic logic [0:47] pc2(input logic [0:55] cd);
      logic [0:47] r;
      for (int i = 0; i < 48; i++) r[i] = cd[PC2[i]];
      return r;
   endfunction

   // Round shift for 0-based round index k is 1 for rounds 1,2,9,16, else 2.
   function automatic logic two_step(input logic [3:0] k);
      return !(k == 4'd0 || k == 4'd1 || k == 4'd8 || k == 4'd15);
   endfunction

   function automatic logic [0:27] rotl(input logic [0:27] x, input logic two);
      return two ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
   endfunction

   function automatic logic [0:27] rotr(input logic [0:27] x, input logic two);
      return two ? {x[26:27], x[0:25]} : {x[27], x[0:26]};
   endfunction

   assign cd0     = pc1(key_in);
   assign accept  = key_ready && key_valid;
   assign advance = subkey_valid && subkey_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nxt    = state;
      key_ready    = 1'b0;
      subkey_valid = 1'b0;
      case (state)
         IDLE: begin
            key_ready = 1'b1;
            if (key_valid) state_nxt = RUN;
         end
         RUN: begin
            subkey_valid = 1'b1;
            if (subkey_ready && cnt_q == 4'd15) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // C/D halves, round counter and mode. Encrypt holds C(n+1) at count n and
   // steps forward by the next round's shift; decrypt holds C(16-n) and steps
   // back by undoing round (16-n)'s shift, i.e. shift index 15-n.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_q    <= '0;
         d_q    <= '0;
         cnt_q  <= '0;
         mode_q <= 1'b0;
      end else if (accept) begin
         mode_q <= key_decrypt;
         cnt_q  <= '0;
         if (key_decrypt) begin
            c_q <= cd0[0:27];
            d_q <= cd0[28:55];
         end else begin
            c_q <= rotl(cd0[0:27], 1'b0);
            d_q <= rotl(cd0[28:55], 1'b0);
         end
      end else if (advance && cnt_q != 4'd15) begin
         cnt_q <= cnt_q + 4'd1;
         if (mode_q) begin
            c_q <= rotr(c_q, two_step(4'd15 - cnt_q));
            d_q <= rotr(d_q, two_step(4'd15 - cnt_q));
         end else begin
            c_q <= rotl(c_q, two_step(cnt_q + 4'd1));
            d_q <= rotl(d_q, two_step(cnt_q + 4'd1));
         end
      end
   end

   // Subkey outputs are forced to zero outside RUN.
   always_comb begin
      subkey       = '0;
      subkey_round = '0;
      subkey_last  = 1'b0;
      if (subkey_valid) begin
         subkey       = pc2({c_q, d_q});
         subkey_round = mode_q ? 4'd15 - cnt_q : cnt_q;
         subkey_last  = (cnt_q == 4'd15);
      end
   end

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: known-answer table, randomized keys/stalls
// against a table-driven DES key schedule model, reset and overlap cases.
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:63] key_in;
   logic        key_decrypt, key_valid, key_ready;
   logic [0:47] subkey;
   logic [3:0]  subkey_round;
   logic        subkey_last, subkey_valid, subkey_ready;

   des_key_schedule dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_decrypt(key_decrypt),
      .key_valid(key_valid), .key_ready(key_ready), .subkey(subkey),
      .subkey_round(subkey_round), .subkey_last(subkey_last),
      .subkey_valid(subkey_valid), .subkey_ready(subkey_ready));

   always #5 clk = ~clk;

   // DES tables, 1-based as published.
   localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
      10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
      7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
      23,19,12,4,26,8, 16,7,27,20,13,2, 41,52,31,37,47,55,
      30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   int n_tests = 0;
   int n_fail  = 0;

   logic [47:0] mk [16];      // model K1..K16
   logic [47:0] exp_q [16];   // expected presentation order
   logic [47:0] obs_first, obs_second, obs_last;
   logic [3:0]  obs_first_rnd, obs_last_rnd;

   typedef struct {
      logic [63:0] key;
      logic        dec;
      logic [47:0] first;
      logic [3:0]  first_rnd;
      logic        has_second;
      logic [47:0] second;
      logic [47:0] last;
      logic [3:0]  last_rnd;
   } vec_t;
   vec_t vt [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: DES key bit n is key[64-n]; C||D bit n is cd[56-n].
   function automatic void model(input logic [63:0] k);
      logic [27:0] c, d;
      logic [55:0] cd;
      for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int r = 0; r < 16; r++) begin
         c = (c << SH[r]) | (c >> (28 - SH[r]));
         d = (d << SH[r]) | (d >> (28 - SH[r]));
         cd = {c, d};
         for (int j = 0; j < 48; j++) mk[r][47-j] = cd[56-PC2_T[j]];
      end
   endfunction

   task automatic start_key(input logic [63:0] k, input logic dec);
      int t = 0;
      while (key_ready !== 1'b1 && t < 50) begin tick(); t++; end
      chk("key_ready_wait", {63'd0, key_ready}, 64'd1);
      key_in = k; key_decrypt = dec; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      key_in = {$urandom, $urandom};
      key_decrypt = 1'($urandom_range(0, 1));
      chk("accept_valid", {63'd0, subkey_valid}, 64'd1);
   endtask

   // Drain 16 subkeys with random stalls; every cycle the held subkey must
   // match the expected one for the current handshake index.
   task automatic collect(input logic [63:0] k, input logic dec, input int rdy_pct,
                          input bit hold_kv, output int cycles);
      int hs = 0;
      logic rdy;
      model(k);
      for (int i = 0; i < 16; i++) exp_q[i] = dec ? mk[15-i] : mk[i];
      cycles = 0;
      while (hs < 16 && cycles < 400) begin
         rdy = ($urandom_range(1, 100) <= rdy_pct);
         if (hold_kv) begin
            key_valid = 1'b1;
            key_in = {$urandom, $urandom};
            key_decrypt = 1'($urandom_range(0, 1));
         end
         chk("sk_valid", {63'd0, subkey_valid}, 64'd1);
         chk("subkey", {16'd0, subkey}, {16'd0, exp_q[hs]});
         chk("round", {60'd0, subkey_round}, dec ? 64'(15 - hs) : 64'(hs));
         chk("last", {63'd0, subkey_last}, {63'd0, hs == 15});
         if (rdy) begin
            if (hs == 0) begin obs_first = subkey; obs_first_rnd = subkey_round; end
            if (hs == 1) obs_second = subkey;
            if (hs == 15) begin obs_last = subkey; obs_last_rnd = subkey_round; end
         end
         subkey_ready = rdy;
         tick();
         cycles++;
         if (rdy) hs++;
      end
      subkey_ready = 1'b0;
      chk("handshakes", 64'(hs), 64'd16);
      chk("idle_after", {63'd0, key_ready}, 64'd1);
      chk("valid_after", {63'd0, subkey_valid}, 64'd0);
      chk("subkey_zero_idle", {16'd0, subkey}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic [63:0] k, k2;
      logic d;

      vt[0] = '{64'h133457799BBCDFF1, 1'b0, 48'h1B02EFFC7072, 4'd0, 1'b1,
                48'h79AED9DBC9E5, 48'hCB3D8B0E17F5, 4'd15};
      vt[1] = '{64'h133457799BBCDFF1, 1'b1, 48'hCB3D8B0E17F5, 4'd15, 1'b0,
                48'h0, 48'h1B02EFFC7072, 4'd0};
      vt[2] = '{64'h0101010101010101, 1'b0, 48'h0, 4'd0, 1'b1, 48'h0, 48'h0, 4'd15};
      vt[3] = '{64'h0101010101010101, 1'b1, 48'h0, 4'd15, 1'b1, 48'h0, 48'h0, 4'd0};

      rst = 1'b1; key_in = '0; key_decrypt = 1'b0; key_valid = 1'b0; subkey_ready = 1'b0;
      #1;
      chk("rst_key_ready", {63'd0, key_ready}, 64'd1);
      chk("rst_valid", {63'd0, subkey_valid}, 64'd0);
      chk("rst_subkey", {16'd0, subkey}, 64'd0);
      chk("rst_round", {60'd0, subkey_round}, 64'd0);
      chk("rst_last", {63'd0, subkey_last}, 64'd0);
      tick(); tick();
      rst = 1'b0;

      // Known-answer table, full-rate drain.
      for (int v = 0; v < 4; v++) begin
         start_key(vt[v].key, vt[v].dec);
         collect(vt[v].key, vt[v].dec, 100, 1'b0, cyc);
         chk("kat_latency", 64'(cyc), 64'd16);
         chk("kat_first", {16'd0, obs_first}, {16'd0, vt[v].first});
         chk("kat_first_rnd", {60'd0, obs_first_rnd}, {60'd0, vt[v].first_rnd});
         if (vt[v].has_second) chk("kat_second", {16'd0, obs_second}, {16'd0, vt[v].second});
         chk("kat_last", {16'd0, obs_last}, {16'd0, vt[v].last});
         chk("kat_last_rnd", {60'd0, obs_last_rnd}, {60'd0, vt[v].last_rnd});
      end

      // Known key with ~50% stalls.
      start_key(64'h133457799BBCDFF1, 1'b0);
      collect(64'h133457799BBCDFF1, 1'b0, 50, 1'b0, cyc);

      // Random keys, modes and stalls.
      for (int r = 0; r < 8; r++) begin
         k = {$urandom, $urandom};
         d = 1'($urandom_range(0, 1));
         start_key(k, d);
         collect(k, d, 50, 1'b0, cyc);
      end

      // key_valid held high with junk during RUN; next key taken in the bubble.
      k  = {$urandom, $urandom};
      k2 = {$urandom, $urandom};
      start_key(k, 1'b0);
      collect(k, 1'b0, 70, 1'b1, cyc);
      key_in = k2; key_decrypt = 1'b0; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      model(k2);
      chk("overlap_accept", {63'd0, subkey_valid}, 64'd1);
      chk("overlap_k1", {16'd0, subkey}, {16'd0, mk[0]});
      collect(k2, 1'b0, 100, 1'b0, cyc);

      // Reset in the middle of a schedule at counter 7.
      start_key(k, 1'b0);
      subkey_ready = 1'b1;
      repeat (7) tick();
      subkey_ready = 1'b0;
      model(k);
      chk("mid_k8", {16'd0, subkey}, {16'd0, mk[7]});
      chk("mid_round", {60'd0, subkey_round}, 64'd7);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", {63'd0, subkey_valid}, 64'd0);
      chk("async_rst_subkey", {16'd0, subkey}, 64'd0);
      chk("async_rst_ready", {63'd0, key_ready}, 64'd1);
      tick();
      chk("rst_hold_subkey", {16'd0, subkey}, 64'd0);
      chk("rst_hold_round", {60'd0, subkey_round}, 64'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_no_stale", {63'd0, subkey_valid}, 64'd0);
      start_key(k2, 1'b0);
      collect(k2, 1'b0, 100, 1'b0, cyc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
